// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives every N_IN-bit vector in
// ascending order, holds each for HOLD cycles and checks dut_out
// against EXPECT[stim] on the last hold cycle of each vector.
// Ports: clk, rst_n (async, active-low), start, dut_out in;
//        stim, busy, done, err_cnt, first_err_vld, first_err_idx out.
// Optional: define SWEEP_STOP_ON_ERR_EN to end the sweep at the
//           first mismatch.
module truth_table_sweeper #(
  parameter int N_IN = 4,
  parameter int HOLD = 20,
  parameter logic [(1<<N_IN)-1:0] EXPECT = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            dut_out,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   err_cnt,
  output logic            first_err_vld,
  output logic [N_IN-1:0] first_err_idx
);

  localparam int NV = 1 << N_IN;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [N_IN-1:0] LAST  = N_IN'(NV - 1);
  localparam logic [HW-1:0]   HLAST = HW'(HOLD - 1);
  localparam logic [HW-1:0]   H_ONE = HW'(1);
  localparam logic [N_IN-1:0] S_ONE = N_IN'(1);
  localparam logic [N_IN:0]   E_ONE = (N_IN+1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q;
  logic [HW-1:0]   hold_q;
  logic [HW-1:0]   hold_d;
  logic [N_IN-1:0] stim_q;
  logic [N_IN-1:0] stim_d;
  logic [N_IN:0]   err_cnt_q;
  logic [N_IN:0]   err_cnt_d;
  logic            fvld_q;
  logic [N_IN-1:0] fidx_q;
  logic            busy_q;
  logic            done_q;

  logic sample;
  logic miss;
  logic last_vec;
  logic finish;

  assign hold_d    = hold_q + H_ONE;
  assign stim_d    = stim_q + S_ONE;
  assign err_cnt_d = err_cnt_q + E_ONE;

  assign sample   = (hold_q == HLAST);
  assign miss     = dut_out ^ EXPECT[stim_q];
  assign last_vec = (stim_q == LAST);

`ifdef SWEEP_STOP_ON_ERR_EN
  // a mismatch ends the sweep with stim parked on the bad vector
  assign finish = last_vec | miss;
`else
  assign finish = last_vec;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      stim_q    <= '0;
      err_cnt_q <= '0;
      fvld_q    <= 1'b0;
      fidx_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q   <= APPLY;
            hold_q    <= '0;
            stim_q    <= '0;
            err_cnt_q <= '0;
            fvld_q    <= 1'b0;
            fidx_q    <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        APPLY: begin
          if (sample) begin
            if (miss) begin
              err_cnt_q <= err_cnt_d;
              if (!fvld_q) begin
                fvld_q <= 1'b1;
                fidx_q <= stim_q;
              end
            end
            if (finish) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              stim_q <= stim_d;
              hold_q <= '0;
            end
          end else begin
            hold_q <= hold_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign stim          = stim_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_vld = fvld_q;
  assign first_err_idx = fidx_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper (N_IN=4, HOLD=20).
// Checks reset, sweeps, start handling and mid-sweep reset.
module tb_truth_table_sweeper;

`ifdef SWEEP_STOP_ON_ERR_EN
  localparam logic [15:0] EXP = 16'h0010;
`else
  localparam logic [15:0] EXP = 16'hA5A5;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       dut_out;
  logic       good_dut;
  logic [3:0] stim;
  logic       busy;
  logic       done;
  logic [4:0] err_cnt;
  logic       first_err_vld;
  logic [3:0] first_err_idx;

  int n_assert;
  int n_fail;

  truth_table_sweeper #(
    .N_IN  (4),
    .HOLD  (20),
    .EXPECT(EXP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .dut_out      (dut_out),
    .stim         (stim),
    .busy         (busy),
    .done         (done),
    .err_cnt      (err_cnt),
    .first_err_vld(first_err_vld),
    .first_err_idx(first_err_idx)
  );

  // modelled DUT: either correct or stuck at 0
  assign dut_out = good_dut ? EXP[stim] : 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".stim"}, 32'(stim), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".err"}, 32'(err_cnt), 0);
    chk({tag, ".fvld"}, 32'(first_err_vld), 0);
    chk({tag, ".fidx"}, 32'(first_err_idx), 0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    start    = 1'b0;
    good_dut = 1'b1;

    // reset with random inputs
    #2;
    rst_n    = 1'b0;
    start    = 1'($urandom);
    good_dut = 1'($urandom);
    #1;
    chk_zero("rst_async");
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom);
      tick();
    end
    chk_zero("rst_hold");
    start    = 1'b0;
    rst_n    = 1'b1;
    good_dut = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk_zero("idle_stay");

`ifdef SWEEP_STOP_ON_ERR_EN
    good_dut = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      chk("stop.busy", 32'(busy), 1);
      chk("stop.stim", 32'(stim), 32'(c / 20));
      tick();
    end
    chk("stop.done", 32'(done), 1);
    chk("stop.busy_lo", 32'(busy), 0);
    chk("stop.stim_end", 32'(stim), 4);
    chk("stop.err", 32'(err_cnt), 1);
    chk("stop.fvld", 32'(first_err_vld), 1);
    chk("stop.fidx", 32'(first_err_idx), 4);
    for (int i = 0; i < 30; i++) tick();
    chk("stop.stim_hold", 32'(stim), 4);
    chk("stop.done_hold", 32'(done), 1);
`else
    // clean sweep
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 320; c++) begin
      chk("clean.busy", 32'(busy), 1);
      chk("clean.done_lo", 32'(done), 0);
      chk("clean.stim", 32'(stim), 32'(c / 20));
      tick();
    end
    chk("clean.done", 32'(done), 1);
    chk("clean.busy_lo", 32'(busy), 0);
    chk("clean.err", 32'(err_cnt), 0);
    chk("clean.fvld", 32'(first_err_vld), 0);
    chk("clean.stim_end", 32'(stim), 15);

    // stuck-at-0, with a start pulse at stim=5 that must be ignored
    good_dut = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_zero_busy: begin
      chk("stuck.busy0", 32'(busy), 1);
      chk("stuck.done0", 32'(done), 0);
    end
    for (int c = 0; c < 320; c++) begin
      chk("stuck.busy", 32'(busy), 1);
      chk("stuck.stim", 32'(stim), 32'(c / 20));
      if (c == 19) chk("stuck.fvld_pre", 32'(first_err_vld), 0);
      if (c == 20) begin
        chk("stuck.err1", 32'(err_cnt), 1);
        chk("stuck.fvld1", 32'(first_err_vld), 1);
      end
      start = (c == 105);
      tick();
    end
    start = 1'b0;
    chk("stuck.done", 32'(done), 1);
    chk("stuck.busy_lo", 32'(busy), 0);
    chk("stuck.err", 32'(err_cnt), 8);
    chk("stuck.fvld", 32'(first_err_vld), 1);
    chk("stuck.fidx", 32'(first_err_idx), 0);
    chk("stuck.stim_end", 32'(stim), 15);
    tick();
    chk("stuck.done_hold", 32'(done), 1);
    chk("stuck.err_hold", 32'(err_cnt), 8);

    // restart from DONE clears results on the same edge
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart.err", 32'(err_cnt), 0);
    chk("restart.stim", 32'(stim), 0);
    chk("restart.busy", 32'(busy), 1);
    chk("restart.done", 32'(done), 0);
    chk("restart.fvld", 32'(first_err_vld), 0);

    // run into vector 7, then reset without a clock edge
    for (int i = 0; i < 145; i++) tick();
    chk("mid.stim", 32'(stim), 7);
    chk("mid.err", 32'(err_cnt), 3);
    chk("mid.fvld", 32'(first_err_vld), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk_zero("post_rst_idle");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
